// File: rtl/realtime_finite_difference_pkg.sv
// Shared widths, sample type and overflow reduction for the lagged finite difference.
// FINITE_DIFFERENCE_SATURATE_EN selects clamping instead of two's-complement wrap.
package realtime_finite_difference_pkg;

  localparam int SAMPLE_WIDTH     = 16;
  localparam int PARALLEL_SAMPLES = 16;
  localparam int CHANNELS         = 8;
  localparam int MAX_LAG          = 32;
  localparam int LAG_BITS         = $clog2(MAX_LAG + 1);
  localparam int HIST_WORDS       = (MAX_LAG + PARALLEL_SAMPLES - 1) / PARALLEL_SAMPLES;
  localparam int HIST_LEN         = HIST_WORDS * PARALLEL_SAMPLES;
  localparam int WORD_WIDTH       = SAMPLE_WIDTH * PARALLEL_SAMPLES;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic signed [SAMPLE_WIDTH:0]   wide_t;

  function automatic sample_t sat_or_wrap(input wide_t v);
`ifdef FINITE_DIFFERENCE_SATURATE_EN
    // Top two bits disagree only when the result left the sample range.
    if (v[SAMPLE_WIDTH] != v[SAMPLE_WIDTH-1])
      return v[SAMPLE_WIDTH] ? sample_t'({1'b1, {(SAMPLE_WIDTH-1){1'b0}}})
                             : sample_t'({1'b0, {(SAMPLE_WIDTH-1){1'b1}}});
    else
      return sample_t'(v[SAMPLE_WIDTH-1:0]);
`else
    return sample_t'(v[SAMPLE_WIDTH-1:0]);
`endif
  endfunction

endpackage

// File: rtl/realtime_finite_difference_channel.sv
// One channel: sample history, per-lane lag operand select, difference stage and reduction stage.
// History only advances on valid words so input gaps do not distort the lag.
module finite_difference_channel
  import realtime_finite_difference_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LAG_BITS-1:0]   lag,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] out_data
);

  localparam int WIN_LEN  = HIST_LEN + PARALLEL_SAMPLES;
  localparam int IDX_BITS = $clog2(WIN_LEN);

  sample_t hist   [HIST_LEN];
  sample_t win    [WIN_LEN];
  wide_t   diff   [PARALLEL_SAMPLES];
  wide_t   diff_q [PARALLEL_SAMPLES];
  logic    valid_q;

  // Window is {history oldest..newest, current word}; lane k of the current word sits at HIST_LEN+k.
  always_comb begin
    for (int i = 0; i < HIST_LEN; i++)
      win[i] = hist[i];
    for (int k = 0; k < PARALLEL_SAMPLES; k++)
      win[HIST_LEN + k] = sample_t'(in_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
  end

  always_comb begin
    for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
      if (lag == '0)
        diff[k] = wide_t'(win[HIST_LEN + k]);
      else
        diff[k] = wide_t'(win[HIST_LEN + k])
                - wide_t'(win[IDX_BITS'(HIST_LEN + k) - IDX_BITS'(lag)]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < HIST_LEN; i++)
        hist[i] <= '0;
    end else begin
      valid_q   <= in_valid;
      out_valid <= valid_q;
      if (in_valid) begin
        for (int i = 0; i < HIST_LEN; i++)
          hist[i] <= win[i + PARALLEL_SAMPLES];
      end
    end
  end

  always_ff @(posedge clk) begin
    diff_q <= diff;
    for (int k = 0; k < PARALLEL_SAMPLES; k++)
      out_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= sat_or_wrap(diff_q[k]);
  end

endmodule

// File: rtl/realtime_finite_difference.sv
// Per-channel lagged difference y[n] = x[n] - x[n-lag], 2-cycle latency, no backpressure.
// Lag is written through an always-ready stream port; FINITE_DIFFERENCE_SATURATE_EN selects clamping.
module realtime_finite_difference
  import realtime_finite_difference_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CHANNELS-1:0][WORD_WIDTH-1:0]  data_in_data,
  input  logic [CHANNELS-1:0]                  data_in_valid,
  output logic [CHANNELS-1:0][WORD_WIDTH-1:0]  data_out_data,
  output logic [CHANNELS-1:0]                  data_out_valid,
  input  logic [LAG_BITS-1:0]                  config_in_data,
  input  logic                                 config_in_valid,
  output logic                                 config_in_ready
);

  logic [LAG_BITS-1:0] lag;

  assign config_in_ready = 1'b1;

  // Out-of-range lag writes are dropped silently.
  always_ff @(posedge clk) begin
    if (reset)
      lag <= LAG_BITS'(1);
    else if (config_in_valid && config_in_ready && (config_in_data <= LAG_BITS'(MAX_LAG)))
      lag <= config_in_data;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    finite_difference_channel u_chan (
      .clk       (clk),
      .reset     (reset),
      .lag       (lag),
      .in_valid  (data_in_valid[c]),
      .in_data   (data_in_data[c]),
      .out_valid (data_out_valid[c]),
      .out_data  (data_out_data[c])
    );
  end

endmodule

// File: tb/tb_realtime_finite_difference.sv
// Bench for realtime_finite_difference: scoreboard model of the lagged difference plus table and corner sequences.
module tb_realtime_finite_difference;
  import realtime_finite_difference_pkg::*;

  localparam int SW = SAMPLE_WIDTH;
  localparam int P  = PARALLEL_SAMPLES;
  localparam int CH = CHANNELS;
  localparam int WW = WORD_WIDTH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [CH-1:0][WW-1:0] data_in_data = '0;
  logic [CH-1:0]         data_in_valid = '0;
  logic [CH-1:0][WW-1:0] data_out_data;
  logic [CH-1:0]         data_out_valid;
  logic [LAG_BITS-1:0]   config_in_data = '0;
  logic                  config_in_valid = 1'b0;
  logic                  config_in_ready;

  always #5 clk = ~clk;

  realtime_finite_difference dut (
    .clk             (clk),
    .reset           (reset),
    .data_in_data    (data_in_data),
    .data_in_valid   (data_in_valid),
    .data_out_data   (data_out_data),
    .data_out_valid  (data_out_valid),
    .config_in_data  (config_in_data),
    .config_in_valid (config_in_valid),
    .config_in_ready (config_in_ready)
  );

  typedef struct { logic [WW-1:0] dat; int due; } exp_t;
  typedef struct { int lag; int words; int expect_val; } vec_t;

  exp_t          sbq [CH][$];
  sample_t       mh [CH][MAX_LAG];
  logic [WW-1:0] last_out [CH];
  int            ramp [CH];
  int            model_lag = 1;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  bit            mon_en = 1'b0;

  vec_t vecs [6] = '{'{1, 3, 1}, '{20, 4, 20}, '{33, 3, 20}, '{7, 3, 7}, '{32, 4, 32}, '{16, 3, 16}};

  task automatic chk(input string nm, input logic [WW-1:0] got, input logic [WW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic sample_t reduce(input int d);
    int r;
    r = d;
`ifdef FINITE_DIFFERENCE_SATURATE_EN
    if (r > (1 <<< (SW-1)) - 1) r = (1 <<< (SW-1)) - 1;
    if (r < -(1 <<< (SW-1)))    r = -(1 <<< (SW-1));
`endif
    return sample_t'(r);
  endfunction

  function automatic logic [WW-1:0] model_word(input int c, input logic [WW-1:0] x);
    logic [WW-1:0] y;
    sample_t a, b;
    y = '0;
    for (int k = 0; k < P; k++) begin
      a = sample_t'(x[k*SW +: SW]);
      if (model_lag == 0)      b = '0;
      else if (k >= model_lag) b = sample_t'(x[(k-model_lag)*SW +: SW]);
      else                     b = mh[c][MAX_LAG + k - model_lag];
      y[k*SW +: SW] = reduce(int'(a) - int'(b));
    end
    return y;
  endfunction

  function automatic logic [WW-1:0] repl(input int val);
    logic [WW-1:0] w;
    for (int k = 0; k < P; k++) w[k*SW +: SW] = SW'(val);
    return w;
  endfunction

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < WW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic set_ramp(input logic [CH-1:0] mask);
    for (int c = 0; c < CH; c++) begin
      if (mask[c]) begin
        for (int k = 0; k < P; k++) data_in_data[c][k*SW +: SW] = SW'(c*1000 + ramp[c] + k);
        ramp[c] += P;
      end
    end
  endtask

  task automatic step(input logic [CH-1:0] v, input bit cv = 1'b0, input int cd = 0, input bit rst = 1'b0);
    exp_t e;
    data_in_valid   = v;
    config_in_valid = cv;
    config_in_data  = LAG_BITS'(cd);
    reset           = rst;
    @(posedge clk);
    cyc++;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        sbq[c].delete();
        for (int i = 0; i < MAX_LAG; i++) mh[c][i] = '0;
      end
      model_lag = 1;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (v[c]) begin
          e.dat = model_word(c, data_in_data[c]);
          e.due = cyc + 1;
          sbq[c].push_back(e);
          for (int i = 0; i < MAX_LAG; i++)
            mh[c][i] = (i < MAX_LAG - P) ? mh[c][i+P] : sample_t'(data_in_data[c][(i-(MAX_LAG-P))*SW +: SW]);
        end
      end
      if (cv && cd <= MAX_LAG) model_lag = cd;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit want;
      exp_t e;
      for (int c = 0; c < CH; c++) begin
        want = (sbq[c].size() > 0) && (sbq[c][0].due == cyc);
        chk($sformatf("valid ch%0d cyc%0d", c, cyc), WW'(data_out_valid[c]), WW'(want));
        if (want) begin
          e = sbq[c].pop_front();
          chk($sformatf("data ch%0d cyc%0d", c, cyc), data_out_data[c], e.dat);
        end
        if (data_out_valid[c] === 1'b1) last_out[c] = data_out_data[c];
      end
    end
  end

  initial begin
    logic [WW-1:0] w;
    logic [CH-1:0][WW-1:0] saved;
    logic [CH-1:0] pat [4];
    pat = '{8'hFF, 8'hF7, 8'hF7, 8'hFF};
    for (int c = 0; c < CH; c++) ramp[c] = 0;

    step('0, 1'b0, 0, 1'b1);
    step('0, 1'b0, 0, 1'b1);
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset valid", WW'(data_out_valid), '0);
    chk("config ready", WW'(config_in_ready), WW'(1));

    // First word after reset with default lag 1: y0 = x0, the rest 1.
    set_ramp('1); step('1);
    step('0); step('0);
    for (int c = 0; c < CH; c++) begin
      w = repl(1);
      w[SW-1:0] = SW'(c*1000);
      chk($sformatf("first word ch%0d", c), last_out[c], w);
    end

    foreach (vecs[i]) begin
      step('0, 1'b1, vecs[i].lag);
      repeat (vecs[i].words) begin set_ramp('1); step('1); end
      step('0); step('0);
      for (int c = 0; c < CH; c++)
        chk($sformatf("table %0d lag%0d ch%0d", i, vecs[i].lag, c), last_out[c], repl(vecs[i].expect_val));
    end

    // Channel 3 gapped, garbage on its invalid cycles.
    step('0, 1'b1, 1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        set_ramp(pat[i]);
        if (!pat[i][3]) data_in_data[3] = rand_word();
        step(pat[i]);
      end
    end
    step('0); step('0);
    chk("gap ch3", last_out[3], repl(1));
    chk("gap ch0", last_out[0], repl(1));

    // Overflow in both directions within one word.
    w = '0;
    w[7*SW +: SW] = 16'h8000;
    w[8*SW +: SW] = 16'h7FFF;
    w[9*SW +: SW] = 16'h8000;
    data_in_data[0] = w;
    step(8'h01); step('0); step('0);
`ifdef FINITE_DIFFERENCE_SATURATE_EN
    chk("step up", WW'(last_out[0][8*SW +: SW]), WW'(16'h7FFF));
    chk("step down", WW'(last_out[0][9*SW +: SW]), WW'(16'h8000));
`else
    chk("step up", WW'(last_out[0][8*SW +: SW]), WW'(16'hFFFF));
    chk("step down", WW'(last_out[0][9*SW +: SW]), WW'(16'h0001));
`endif

    // Config on the same cycle as a word: that word keeps lag 1, the next uses lag 0.
    set_ramp(8'h02);
    step(8'h02, 1'b1, 0);
    step('0); step('0);
    chk("same-cycle cfg old lag", last_out[1], repl(1));
    w = rand_word();
    data_in_data[1] = w;
    step(8'h02); step('0); step('0);
    chk("lag0 identity", last_out[1], w);

    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < CH; c++) data_in_data[c] = rand_word();
      step(CH'($urandom), ($urandom_range(0, 9) == 0), $urandom_range(0, 40));
    end

    // Reset mid-stream with words in flight.
    for (int c = 0; c < CH; c++) data_in_data[c] = rand_word();
    step('1);
    step('1, 1'b1, 5);
    step('1, 1'b0, 0, 1'b1);
    @(negedge clk);
    chk("valid reset+0", WW'(data_out_valid), '0);
    for (int c = 0; c < CH; c++) data_in_data[c] = rand_word();
    saved = data_in_data;
    step('1);
    @(negedge clk);
    chk("valid reset+1", WW'(data_out_valid), '0);
    step('0);
    @(negedge clk);
    chk("valid reset+2", WW'(data_out_valid), WW'({CH{1'b1}}));
    for (int c = 0; c < CH; c++)
      chk($sformatf("post reset y0 ch%0d", c), WW'(data_out_data[c][SW-1:0]), WW'(saved[c][SW-1:0]));
    step('0); step('0);

    for (int c = 0; c < CH; c++)
      chk($sformatf("drain ch%0d", c), WW'(sbq[c].size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
